// File: rtl/iq_phase_demod.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iq_phase_demod: pipelined vectoring CORDIC, I/Q -> 13-bit phase, averaged FCW estimate.
// Optional magnitude output under PHASE_DEMOD_MAG_EN. Revision 1.0
// ---------------------------------------------------------------------------
module iq_phase_demod #(
  parameter int ITER     = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] sin_in,
  input  logic [15:0] cos_in,
  output logic        out_valid,
  output logic [12:0] phase,
  output logic [16:0] mag,
  output logic        fcw_valid,
  output logic [14:0] fcw_est
);

  localparam int SW = 13 + AVG_LOG2;
  // atan(2^-i) in 1/32 phase LSBs (full circle = 8192*32)
  localparam logic [17:0] c_ATAN [0:15] = '{
    18'd32768, 18'd19344, 18'd10221, 18'd5188, 18'd2604, 18'd1303, 18'd652, 18'd326,
    18'd163,   18'd81,    18'd41,    18'd20,   18'd10,   18'd5,    18'd3,   18'd1
  };
  localparam logic signed [SW-1:0] c_RND_TERM = SW'((1 << AVG_LOG2) >> 1);
  localparam logic [AVG_LOG2:0]    c_CNT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic signed [17:0] r_x [0:ITER-1];
  logic signed [17:0] r_y [0:ITER-1];
  logic        [17:0] r_z [0:ITER];
  logic [ITER:0]      r_vp;
  logic [ITER:0]      r_zp;

  logic signed [17:0] w_sin18;
  logic signed [17:0] w_cos18;
  assign w_sin18 = {{2{sin_in[15]}}, sin_in};
  assign w_cos18 = {{2{cos_in[15]}}, cos_in};

  // Fold the left half-plane onto the right so the CORDIC only sees |angle| <= 90 deg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x[0] <= '0;
      r_y[0] <= '0;
      r_z[0] <= '0;
      r_vp   <= '0;
      r_zp   <= '0;
    end else begin
      r_vp <= {r_vp[ITER-1:0], in_valid};
      r_zp <= {r_zp[ITER-1:0], (sin_in == 16'd0) && (cos_in == 16'd0)};
      if (cos_in[15]) begin
        r_x[0] <= -w_cos18;
        r_y[0] <= -w_sin18;
        r_z[0] <= 18'h20000;
      end else begin
        r_x[0] <= w_cos18;
        r_y[0] <= w_sin18;
        r_z[0] <= '0;
      end
    end
  end

`ifdef PHASE_DEMOD_MAG_EN
  logic [17:0] r_xf;
  logic [16:0] r_mag;
`endif

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    logic w_pos;
    assign w_pos = ~r_y[i][17];

    always_ff @(posedge clk) begin
      if (rst)        r_z[i+1] <= '0;
      else if (w_pos) r_z[i+1] <= r_z[i] + c_ATAN[i];
      else            r_z[i+1] <= r_z[i] - c_ATAN[i];
    end

    // The last stage only needs the angle, plus x when magnitude is built
    if (i < ITER - 1) begin : g_xy
      always_ff @(posedge clk) begin
        if (rst) begin
          r_x[i+1] <= '0;
          r_y[i+1] <= '0;
        end else begin
          r_x[i+1] <= w_pos ? r_x[i] + (r_y[i] >>> i) : r_x[i] - (r_y[i] >>> i);
          r_y[i+1] <= w_pos ? r_y[i] - (r_x[i] >>> i) : r_y[i] + (r_x[i] >>> i);
        end
      end
    end else begin : g_xf
`ifdef PHASE_DEMOD_MAG_EN
      always_ff @(posedge clk) begin
        if (rst) r_xf <= '0;
        else     r_xf <= w_pos ? r_x[i] + (r_y[i] >>> i) : r_x[i] - (r_y[i] >>> i);
      end
`endif
    end
  end

  logic [12:0]          w_phase_next;
  logic signed [12:0]   w_delta;
  logic signed [SW-1:0] w_sum;

  logic                 r_out_valid;
  logic [12:0]          r_phase;
  logic [12:0]          r_prev;
  logic                 r_have_prev;
  logic signed [SW-1:0] r_acc;
  logic [AVG_LOG2:0]    r_cnt;
  logic                 r_fcw_valid;
  logic [12:0]          r_fcw;

  // Round-half-up from the 5 fractional bits; an all-zero input has no angle
  assign w_phase_next = r_zp[ITER] ? 13'd0 : r_z[ITER][17:5] + {12'd0, r_z[ITER][4]};
  assign w_delta      = w_phase_next - r_prev;
  assign w_sum        = r_acc + SW'(w_delta);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_phase     <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_fcw_valid <= 1'b0;
      r_fcw       <= '0;
    end else begin
      r_out_valid <= r_vp[ITER];
      r_fcw_valid <= 1'b0;
      if (r_vp[ITER]) begin
        r_phase     <= w_phase_next;
        r_prev      <= w_phase_next;
        r_have_prev <= 1'b1;
        if (r_have_prev) begin
          if (r_cnt == c_CNT_LAST) begin
            r_fcw       <= 13'((w_sum + c_RND_TERM) >>> AVG_LOG2);
            r_fcw_valid <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef PHASE_DEMOD_MAG_EN
  // 19898/32768 ~= 1/1.6468 removes the CORDIC gain
  always_ff @(posedge clk) begin
    if (rst)             r_mag <= '0;
    else if (r_vp[ITER]) r_mag <= 17'((35'(r_xf) * 35'd19898 + 35'd16384) >> 15);
  end
  assign mag = r_mag;
`else
  assign mag = '0;
`endif

  assign out_valid = r_out_valid;
  assign phase     = r_phase;
  assign fcw_valid = r_fcw_valid;
  assign fcw_est   = {2'b00, r_fcw};

endmodule
`default_nettype wire

// File: tb/tb_iq_phase_demod.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iq_phase_demod: static vectors, NCO streams and mid-stream reset. Revision 1.0
// ---------------------------------------------------------------------------
module tb_iq_phase_demod;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] sin_in;
  logic [15:0] cos_in;
  logic        out_valid;
  logic [12:0] phase;
  logic [16:0] mag;
  logic        fcw_valid;
  logic [14:0] fcw_est;

  iq_phase_demod #(.ITER(12), .AVG_LOG2(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sin_in(sin_in), .cos_in(cos_in),
    .out_valid(out_valid), .phase(phase), .mag(mag),
    .fcw_valid(fcw_valid), .fcw_est(fcw_est)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ph; int mg; int due; } exp_t;
  typedef struct { logic signed [15:0] s; logic signed [15:0] c; int ph; int mg; } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   outs_since = 0;
  int   exp_gap = 17;
  int   pulses = 0;
  int   outs_total = 0;
  bit   fcw_on = 1'b0;
  int   exp_fcw = 0;
  int   fcw_tol = 0;

  function automatic int wrapd(int a, int b);
    int d;
    d = (a - b) % 8192;
    if (d < 0) d += 8192;
    if (d > 4096) d -= 8192;
    return d;
  endfunction

  function automatic void chk(string nm, int act, int expv, int tol, bit circ);
    int d;
    total++;
    d = circ ? wrapd(act, expv) : act - expv;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", nm, act, expv, tol, cyc);
    end
  endfunction

  function automatic int exp_mag(int m);
`ifdef PHASE_DEMOD_MAG_EN
    return m;
`else
    return (m == 12345678) ? 1 : 0;
`endif
  endfunction

  function automatic int rnd(real x);
    return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid) begin
      outs_since++;
      outs_total++;
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0, 0, 1'b0);
      end else begin
        e = q.pop_front();
        chk("phase", int'(phase), e.ph, 1, 1'b1);
        chk("latency", cyc, e.due, 0, 1'b0);
        if (e.mg >= 0) chk("mag", int'(mag), e.mg, 2, 1'b0);
      end
    end
    if (fcw_valid) begin
      chk("fcw_align", int'(out_valid), 1, 0, 1'b0);
      chk("fcw_gap", outs_since, exp_gap, 0, 1'b0);
      outs_since = 0;
      exp_gap    = 16;
      pulses++;
      if (fcw_on) chk("fcw_est", int'(fcw_est), exp_fcw, fcw_tol, 1'b1);
    end
  end

  task automatic step(input logic r, input logic v, input logic signed [15:0] s,
                      input logic signed [15:0] c, input int ph, input int mg);
    rst      = r;
    in_valid = v;
    sin_in   = s;
    cos_in   = c;
    if (v && !r) q.push_back(exp_t'{ph, mg, cyc + 14});
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      outs_since = 0;
      exp_gap    = 17;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 0, 0);
  endtask

  task automatic nco(input int p);
    real a;
    a = 6.283185307179586 * real'(p) / 8192.0;
    step(1'b0, 1'b1, 16'(rnd(30000.0 * $sin(a))), 16'(rnd(30000.0 * $cos(a))), p, exp_mag(-1));
  endtask

  task automatic flush();
    for (int k = 0; k < 60 && q.size() > 0; k++) idle();
    idle();
    idle();
    chk("queue_drained", q.size(), 0, 0, 1'b0);
  endtask

  task automatic stream(input int p0, input int fcw, input int n, input bit gaps, input int tol);
    int sent;
    int p;
    step(1'b1, 1'b0, 16'sd0, 16'sd0, 0, 0);
    pulses     = 0;
    outs_total = 0;
    fcw_on     = 1'b1;
    exp_fcw    = fcw;
    fcw_tol    = tol;
    sent       = 0;
    p          = p0;
    while (sent < n) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        idle();
      end else begin
        nco(p);
        p = (p + fcw) % 8192;
        sent++;
      end
    end
    flush();
    chk("out_count", outs_total, n, 0, 1'b0);
    chk("fcw_pulses", pulses, (n - 1) / 16, 0, 1'b0);
    fcw_on = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0, 0, 1'b0);
    chk({tag, "_fcw_valid"}, int'(fcw_valid), 0, 0, 1'b0);
    chk({tag, "_phase"},     int'(phase),     0, 0, 1'b0);
    chk({tag, "_mag"},       int'(mag),       0, 0, 1'b0);
    chk({tag, "_fcw_est"},   int'(fcw_est),   0, 0, 1'b0);
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL timeout: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl [0:7];
    int   p;
    rst      = 1'b1;
    in_valid = 1'b0;
    sin_in   = '0;
    cos_in   = '0;

    tbl[0] = '{16'sd0,      16'sd16384,  0,    16384};
    tbl[1] = '{16'sd16384,  16'sd0,      2048, 16384};
    tbl[2] = '{16'sd0,     -16'sd16384,  4096, 16384};
    tbl[3] = '{-16'sd16384, 16'sd0,      6144, 16384};
    tbl[4] = '{-16'sd32768, -16'sd32768, 5120, 46341};
    tbl[5] = '{16'sd9000,   16'sd12000,  839,  15000};
    tbl[6] = '{16'sd1,     -16'sd32768,  4096, 32768};
    tbl[7] = '{16'sd0,      16'sd0,      0,    0};

    step(1'b1, 1'b0, 16'sd0, 16'sd0, 0, 0);
    step(1'b1, 1'b0, 16'sd0, 16'sd0, 0, 0);
    @(negedge clk);
    check_zero("reset");

    for (int r = 0; r < 8; r++)
      repeat (20) step(1'b0, 1'b1, tbl[r].s, tbl[r].c, tbl[r].ph, exp_mag(tbl[r].mg));
    flush();

    stream(0,    100,  161, 1'b0, 1);
    stream(50,   8000, 161, 1'b0, 1);
    stream(8191, 1,    33,  1'b0, 0);
    stream(7,    256,  161, 1'b1, 0);

    // Reset with the pipe full and a window half accumulated
    step(1'b1, 1'b0, 16'sd0, 16'sd0, 0, 0);
    fcw_on  = 1'b1;
    exp_fcw = 100;
    fcw_tol = 1;
    p = 0;
    repeat (25) begin
      nco(p);
      p = (p + 100) % 8192;
    end
    step(1'b1, 1'b1, 16'sd1000, 16'sd1000, 0, 0);
    pulses     = 0;
    outs_total = 0;
    @(negedge clk);
    check_zero("rst_mid");
    repeat (49) begin
      nco(p);
      p = (p + 100) % 8192;
    end
    flush();
    chk("rst_out_count", outs_total, 49, 0, 1'b0);
    chk("rst_fcw_pulses", pulses, 3, 0, 1'b0);
    fcw_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iq_phase_demod.md
# iq_phase_demod

Recovers the instantaneous phase and frequency word from a quadrature sin/cos sample stream. It performs the inverse of the NCO: the NCO turns a 13-bit phase accumulator into signed 16-bit sin/cos. This block converts sin/cos back into a 13-bit phase in the same units, using a pipelined vectoring-mode CORDIC. It then averages phase differences into an FCW estimate. It sits downstream of the NCO or ADC I/Q path and is used for loopback self-test and carrier frequency measurement.

## Interface
Parameters:
- ITER, 12, number of CORDIC micro-rotation stages (8..16).
- AVG_LOG2, 4, log2 of the number of phase deltas averaged per FCW estimate (0..8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  sample strobe; one sample per cycle maximum, no backpressure.
- sin_in  in  16  signed quadrature (Q) sample.
- cos_in  in  16  signed in-phase (I) sample.
- out_valid  out  1  phase/mag valid strobe.
- phase  out  13  unsigned phase; full circle = 8192.
- mag  out  17  unsigned magnitude (see Configuration).
- fcw_valid  out  1  one-cycle pulse when fcw_est updates.
- fcw_est  out  15  averaged phase increment per sample, zero-extended from 13 bits.

## Operation
- Phase convention: phase = round(atan2(sin_in, cos_in)·8192/2π) mod 8192, so (sin=0, cos>0) gives 0 and (sin>0, cos=0) gives 2048.
- Pre-rotation stage:
  - Sign-extend both inputs to 18 bits, so -32768 negates safely.
  - If cos<0: negate both values and set the base angle to 4096. Otherwise the base angle is 0.
- CORDIC stages i=0..ITER-1:
  - Use an 18-bit internal angle: 13 integer bits plus 5 fractional bits.
  - Constant table atan(2^-i)·8192·32/2π, rounded.
  - If y≥0: x+=y>>>i, y-=x>>>i, angle+=table[i]. Otherwise do the opposite.
  - All stages are registered.
- Output stage:
  - phase = (angle + 16) >> 5, truncated mod 8192.
  - Input (0,0) yields phase 0, mag 0.
- Frequency path, on each out_valid:
  - delta = phase − prev_phase, taken as a 13-bit wrapped value interpreted as signed (−4096..4095).
  - prev_phase is updated every out_valid.
  - The first out_valid after reset only loads prev_phase; it produces no delta.
- Averaging:
  - 2^AVG_LOG2 deltas are summed into a signed (13+AVG_LOG2)-bit accumulator.
  - On the last delta of a window: fcw_est = ((sum + 2^(AVG_LOG2−1)) >>> AVG_LOG2) mod 8192, fcw_valid pulses, and the accumulator and counter clear.
  - With AVG_LOG2=0 there is no rounding term; each delta is published directly.
- in_valid gaps are allowed. Deltas span consecutive valid samples, not clock cycles.

## Timing
- Latency from in_valid to out_valid: exactly ITER+2 cycles (14 at default). Throughput is 1 sample/cycle.
- out_valid is the in_valid delayed through the valid shift pipe; bubbles are preserved.
- fcw_valid asserts on the same cycle as the out_valid that completes a window; the new fcw_est is visible on that cycle.
- fcw_est holds its value between pulses.
- Reset, including mid-stream:
  - Clears the valid pipe, all data pipe registers, accumulator, window counter, prev_phase and the first-sample flag.
  - phase=0, mag=0, fcw_est=0, out_valid=0, fcw_valid=0.
  - In-flight samples are discarded. The first window after reset needs 2^AVG_LOG2+1 valid samples.
- Simultaneous in_valid and rst: rst wins; the sample is dropped.

## Configuration
- PHASE_DEMOD_MAG_EN defined:
  - mag = round(x_final·19898/32768), compensating the CORDIC gain of 1.6468.
  - The result is registered inside the output stage, so latency is unchanged.
  - Accuracy: |mag − sqrt(sin²+cos²)| ≤ 2.
- PHASE_DEMOD_MAG_EN undefined: mag is tied to 0 and no multiplier is inferred. The phase and FCW paths are bit-identical in both builds.

## Test plan
- Static vectors, each held for 20 valid cycles:
  - (sin=0, cos=16384) → phase 0.
  - (16384, 0) → 2048.
  - (0, −16384) → 4096.
  - (−16384, 0) → 6144.
  - (−32768, −32768) → 5120.
  - Tolerance ±1 LSB; out_valid exactly 14 cycles after in_valid.
- Ideal NCO stream at amplitude 30000, FCW=100, continuous valid:
  - Every fcw_valid after the first window gives fcw_est = 100 ±1.
  - fcw_valid pulses every 16 samples.
- Negative-wrap stream, FCW=8000 (−192 mod 8192):
  - fcw_est = 8000 ±1.
  - FCW=1 from phase 8191 across the wrap gives fcw_est = 1.
- Random in_valid gaps (50% duty), FCW=256:
  - fcw_est = 256.
  - Count of out_valid equals count of in_valid; each sample delayed exactly 14 cycles.
- Assert rst for 1 cycle mid-window with the pipe full:
  - Next cycle all outputs are 0.
  - No out_valid for 14 cycles after the next in_valid.
  - First fcw_valid only after 17 valid samples.
- With PHASE_DEMOD_MAG_EN, input (9000, 12000) → mag 15000 ±2. Without the macro, mag stays 0.
